// File: rtl/ex_stage_mc_if.sv
// ---------------------------------------------------------------------------
// ex_stage_mc_if
//   Bundle of the ID/EX-side inputs, hazard-unit controls and EX/MEM outputs
//   of the execute stage.
//
//   master : drives the ID/EX fields and hazard controls, observes EX/MEM
//   slave  : the execute stage itself
//
//   Signals
//     valid_i, pc_i, r1_data_i, r2_data_i, imm_i   ID/EX instruction fields
//     fwd_m_i, fwd_w_i, src1_sel_i, src2_sel_i     forwarding network
//     use_imm_i, alu_op_i, rd_i                    operation select
//     regwrite_i, memread_i, memwrite_i, memtoreg_i control vector
//     flush_i, stall_i                             EX/MEM hazard controls
//     busy_o                                       upstream hold request
//     valid_o, pc_o, alu_out_o, write_data_o,
//     write_reg_o, regwrite_o, memread_o,
//     memwrite_o, memtoreg_o, zero_o               EX/MEM register
// ---------------------------------------------------------------------------
interface ex_stage_mc_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned REG_WIDTH  = 4
);
    logic                  valid_i;
    logic [ADDR_WIDTH-1:0] pc_i;
    logic [DATA_WIDTH-1:0] r1_data_i;
    logic [DATA_WIDTH-1:0] r2_data_i;
    logic [DATA_WIDTH-1:0] imm_i;
    logic [DATA_WIDTH-1:0] fwd_m_i;
    logic [DATA_WIDTH-1:0] fwd_w_i;
    logic [1:0]            src1_sel_i;
    logic [1:0]            src2_sel_i;
    logic                  use_imm_i;
    logic [2:0]            alu_op_i;
    logic [REG_WIDTH-1:0]  rd_i;
    logic                  regwrite_i;
    logic                  memread_i;
    logic                  memwrite_i;
    logic                  memtoreg_i;
    logic                  flush_i;
    logic                  stall_i;

    logic                  busy_o;
    logic                  valid_o;
    logic [ADDR_WIDTH-1:0] pc_o;
    logic [DATA_WIDTH-1:0] alu_out_o;
    logic [DATA_WIDTH-1:0] write_data_o;
    logic [REG_WIDTH-1:0]  write_reg_o;
    logic                  regwrite_o;
    logic                  memread_o;
    logic                  memwrite_o;
    logic                  memtoreg_o;
    logic                  zero_o;

    modport master (
        output valid_i, pc_i, r1_data_i, r2_data_i, imm_i, fwd_m_i, fwd_w_i,
               src1_sel_i, src2_sel_i, use_imm_i, alu_op_i, rd_i,
               regwrite_i, memread_i, memwrite_i, memtoreg_i, flush_i, stall_i,
        input  busy_o, valid_o, pc_o, alu_out_o, write_data_o, write_reg_o,
               regwrite_o, memread_o, memwrite_o, memtoreg_o, zero_o
    );

    modport slave (
        input  valid_i, pc_i, r1_data_i, r2_data_i, imm_i, fwd_m_i, fwd_w_i,
               src1_sel_i, src2_sel_i, use_imm_i, alu_op_i, rd_i,
               regwrite_i, memread_i, memwrite_i, memtoreg_i, flush_i, stall_i,
        output busy_o, valid_o, pc_o, alu_out_o, write_data_o, write_reg_o,
               regwrite_o, memread_o, memwrite_o, memtoreg_o, zero_o
    );
endinterface

// File: rtl/ex_stage_mc.sv
// ---------------------------------------------------------------------------
// ex_stage_mc
//   Execute stage with EX/MEM pipeline register. Full ALU (ADD, SUB, AND, OR,
//   XOR, SLL, SRL), immediate operand B, M/W-stage forwarding, and an
//   optional iterative shift-add multiplier (alu_op 7).
//
//   Build option: define EX_MUL_EN to compile in the multiplier and its
//   IDLE/MUL/DONE sequencer. Without it, alu_op 7 executes as ADD in one
//   cycle and busy_o is tied low.
//
//   Ports
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     ex_if  : ex_stage_mc_if.slave (ID/EX inputs, hazard controls,
//              busy_o and the EX/MEM register outputs)
// ---------------------------------------------------------------------------
module ex_stage_mc #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned REG_WIDTH  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    ex_stage_mc_if.slave  ex_if
);

    localparam int unsigned SH_W = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLL = 3'd5,
        OP_SRL = 3'd6,
        OP_MUL = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] alu;
        logic [DATA_WIDTH-1:0] wdata;
        logic [REG_WIDTH-1:0]  wreg;
        logic                  regwrite;
        logic                  memread;
        logic                  memwrite;
        logic                  memtoreg;
        logic                  zero;
    } exmem_t;

    // ------------------------------------------------------------------
    // Operand selection and single-cycle ALU
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_op_a;
    logic [DATA_WIDTH-1:0] w_op2;
    logic [DATA_WIDTH-1:0] w_op_b;
    logic [DATA_WIDTH-1:0] w_alu;
    alu_op_e               w_op;

    assign w_op = alu_op_e'(ex_if.alu_op_i);

    always_comb begin
        w_op_a = ex_if.r1_data_i;
        case (ex_if.src1_sel_i)
            2'd1:    w_op_a = ex_if.fwd_m_i;
            2'd2:    w_op_a = ex_if.fwd_w_i;
            default: w_op_a = ex_if.r1_data_i;
        endcase
    end

    always_comb begin
        w_op2 = ex_if.r2_data_i;
        case (ex_if.src2_sel_i)
            2'd1:    w_op2 = ex_if.fwd_m_i;
            2'd2:    w_op2 = ex_if.fwd_w_i;
            default: w_op2 = ex_if.r2_data_i;
        endcase
    end

    assign w_op_b = ex_if.use_imm_i ? ex_if.imm_i : w_op2;

    // OP_MUL falls through to ADD: without the multiplier that is its
    // defined behaviour, and with it this result is never loaded.
    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD:  w_alu = w_op_a + w_op_b;
            OP_SUB:  w_alu = w_op_a - w_op_b;
            OP_AND:  w_alu = w_op_a & w_op_b;
            OP_OR:   w_alu = w_op_a | w_op_b;
            OP_XOR:  w_alu = w_op_a ^ w_op_b;
            OP_SLL:  w_alu = w_op_a << w_op_b[SH_W-1:0];
            OP_SRL:  w_alu = w_op_a >> w_op_b[SH_W-1:0];
            OP_MUL:  w_alu = w_op_a + w_op_b;
            default: w_alu = w_op_a + w_op_b;
        endcase
    end

    logic w_busy;

`ifdef EX_MUL_EN
    // ------------------------------------------------------------------
    // Iterative multiplier: IDLE -> MUL -> DONE
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Bit 0 is consumed in the launch cycle, so the MUL state needs
    // DATA_WIDTH-1 further steps; leave MUL as the count steps to DW-1.
    localparam logic [SH_W-1:0] CNT_LAST = SH_W'(DATA_WIDTH - 2);

    state_e                r_state;
    state_e                w_state_nxt;
    logic                  w_launch;
    logic                  w_done_load;

    logic [DATA_WIDTH-1:0] r_mcand;
    logic [DATA_WIDTH-1:0] r_mplier;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [SH_W-1:0]       r_cnt;
    logic [DATA_WIDTH-1:0] r_opnd2;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [REG_WIDTH-1:0]  r_rd;
    logic                  r_regwrite;
    logic                  r_memread;
    logic                  r_memwrite;
    logic                  r_memtoreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_done_load = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ex_if.valid_i && (w_op == OP_MUL)) begin
                    w_busy = 1'b1;
                    if (!ex_if.flush_i) begin
                        w_launch    = 1'b1;
                        w_state_nxt = S_MUL;
                    end
                end
            end
            S_MUL: begin
                w_busy = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!ex_if.stall_i) begin
                    w_done_load = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (ex_if.flush_i) begin
            w_state_nxt = S_IDLE;
            w_done_load = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_opnd2    <= '0;
            r_pc       <= '0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
        end else if (w_launch) begin
            r_acc      <= w_op_b[0] ? w_op_a : '0;
            r_mcand    <= w_op_a << 1;
            r_mplier   <= w_op_b >> 1;
            r_cnt      <= '0;
            r_opnd2    <= w_op2;
            r_pc       <= ex_if.pc_i;
            r_rd       <= ex_if.rd_i;
            r_regwrite <= ex_if.regwrite_i;
            r_memread  <= ex_if.memread_i;
            r_memwrite <= ex_if.memwrite_i;
            r_memtoreg <= ex_if.memtoreg_i;
        end else if (r_state == S_MUL) begin
            r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + SH_W'(1);
        end
    end
`else
    assign w_busy = 1'b0;
`endif

    // busy_o is combinational; gating with rst_n keeps it low during reset
    // even when ID/EX still presents a multiply.
    assign ex_if.busy_o = rst_n & w_busy;

    // ------------------------------------------------------------------
    // EX/MEM register: flush > stall > busy bubble > product > normal
    // ------------------------------------------------------------------
    exmem_t r_exmem;
    exmem_t w_exmem_nxt;

    always_comb begin
        w_exmem_nxt = r_exmem;
        if (ex_if.flush_i) begin
            w_exmem_nxt = '0;
        end else if (ex_if.stall_i) begin
            w_exmem_nxt = r_exmem;
        end else if (w_busy) begin
            w_exmem_nxt = '0;
`ifdef EX_MUL_EN
        end else if (w_done_load) begin
            w_exmem_nxt.valid    = 1'b1;
            w_exmem_nxt.pc       = r_pc;
            w_exmem_nxt.alu      = r_acc;
            w_exmem_nxt.wdata    = r_opnd2;
            w_exmem_nxt.wreg     = r_rd;
            w_exmem_nxt.regwrite = r_regwrite;
            w_exmem_nxt.memread  = r_memread;
            w_exmem_nxt.memwrite = r_memwrite;
            w_exmem_nxt.memtoreg = r_memtoreg;
            w_exmem_nxt.zero     = (r_acc == '0);
`endif
        end else begin
            w_exmem_nxt.valid    = ex_if.valid_i;
            w_exmem_nxt.pc       = ex_if.pc_i;
            w_exmem_nxt.alu      = w_alu;
            w_exmem_nxt.wdata    = w_op2;
            w_exmem_nxt.wreg     = ex_if.rd_i;
            w_exmem_nxt.regwrite = ex_if.valid_i & ex_if.regwrite_i;
            w_exmem_nxt.memread  = ex_if.valid_i & ex_if.memread_i;
            w_exmem_nxt.memwrite = ex_if.valid_i & ex_if.memwrite_i;
            w_exmem_nxt.memtoreg = ex_if.valid_i & ex_if.memtoreg_i;
            w_exmem_nxt.zero     = (w_alu == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exmem <= '0;
        end else begin
            r_exmem <= w_exmem_nxt;
        end
    end

    assign ex_if.valid_o      = r_exmem.valid;
    assign ex_if.pc_o         = r_exmem.pc;
    assign ex_if.alu_out_o    = r_exmem.alu;
    assign ex_if.write_data_o = r_exmem.wdata;
    assign ex_if.write_reg_o  = r_exmem.wreg;
    assign ex_if.regwrite_o   = r_exmem.regwrite;
    assign ex_if.memread_o    = r_exmem.memread;
    assign ex_if.memwrite_o   = r_exmem.memwrite;
    assign ex_if.memtoreg_o   = r_exmem.memtoreg;
    assign ex_if.zero_o       = r_exmem.zero;

endmodule
